// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between fetch (I) and memory-stage (D) ports.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be in 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       owner_d;
    logic       is_store;
    logic       grant_i, grant_d;
    logic       capture;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    logic [3:0] starve;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
`ifdef MEM_ARB_STARVE_GUARD_EN
                if (i_req && (!d_req || starve == STARVE_LIM)) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
`else
                if (d_req) begin
                    grant_d = 1'b1;
                end else if (i_req) begin
                    grant_i = 1'b1;
                end
`endif
                if (grant_i || grant_d) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = LAT_M1;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // mem_* registers double as the latched request fields; they are only non-zero during ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            is_store  <= 1'b0;
            i_rdata   <= '0;
            i_ack     <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            mem_en <= grant_i || grant_d;
            if (grant_d) begin
                owner_d   <= 1'b1;
                is_store  <= d_we;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end else if (grant_i) begin
                owner_d   <= 1'b0;
                is_store  <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
                mem_be    <= '1;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                mem_be    <= '0;
            end
            i_ack <= capture && !owner_d;
            d_ack <= capture && owner_d;
            if (capture && !owner_d) begin
                i_rdata <= mem_rdata;
            end
            if (capture && owner_d && !is_store) begin
                d_rdata <= mem_rdata;
            end
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    // Counts D wins while a fetch was waiting; any fetch grant or fetch-free IDLE cycle clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (grant_i || !i_req) begin
                starve <= '0;
            end else if (grant_d && starve != 4'hF) begin
                starve <= starve + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural fixed-latency memory plus queued expectations
// for every memory issue and every ack, checked in order as the DUT produces them.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;

    mem_port_arbiter #(
        .MEM_LATENCY (LAT),
        .STARVE_LIMIT(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] data;
        int          exp_cyc;
    } exp_t;

    exp_t issue_q[$];
    exp_t ack_q[$];

    logic [31:0] ref_mem[int];
    logic [31:0] sim_mem[int];
    logic [31:0] due[int];
    logic [31:0] exp_d_rdata = '0;
    int          issue_cyc = 0;

    function automatic logic [31:0] init_word(input int k);
        logic [31:0] a;
        a = 32'(k);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input int k);
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] sim_rd(input int k);
        return sim_mem.exists(k) ? sim_mem[k] : init_word(k);
    endfunction

    // Expectations are pushed in the order the arbiter is required to grant.
    task automatic push(input logic is_d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int exp_cyc, input logic acked);
        exp_t e;
        int k;
        k         = int'(addr[31:2]);
        e.is_d    = is_d;
        e.we      = is_d & we;
        e.addr    = addr;
        e.wdata   = is_d ? wdata : 32'h0;
        e.be      = is_d ? be : 4'hF;
        e.exp_cyc = exp_cyc;
        if (e.we) begin
            e.data     = exp_d_rdata;
            ref_mem[k] = merge(ref_rd(k), wdata, be);
        end else begin
            e.data = ref_rd(k);
            if (is_d) exp_d_rdata = e.data;
        end
        issue_q.push_back(e);
        if (acked) ack_q.push_back(e);
    endtask

    // Memory model and issue checker.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (due.exists(cyc)) begin
            mem_rdata = due[cyc];
            due.delete(cyc);
        end else begin
            mem_rdata = 32'hBAD0_BAD0;
        end
        if (mem_en) begin
            k = int'(mem_addr[31:2]);
            due[cyc + LAT] = sim_rd(k);
            if (mem_we) sim_mem[k] = merge(sim_rd(k), mem_wdata, mem_be);
            issue_cyc = cyc;
            if (issue_q.size() == 0) begin
                check("mem_en_unexpected", 32'(mem_en), 32'h0);
            end else begin
                e = issue_q.pop_front();
                check("mem_addr", mem_addr, e.addr);
                check("mem_we", 32'(mem_we), 32'(e.we));
                check("mem_wdata", mem_wdata, e.wdata);
                check("mem_be", 32'(mem_be), 32'(e.be));
            end
        end
    end

    // Ack monitor.
    always @(negedge clk) begin
        exp_t e;
        if (i_ack || d_ack) begin
            check("ack_exclusive", 32'(i_ack & d_ack), 32'h0);
            if (ack_q.size() == 0) begin
                check("ack_unexpected", 32'(i_ack | d_ack), 32'h0);
            end else begin
                e = ack_q.pop_front();
                check("ack_side", 32'(d_ack), 32'(e.is_d));
                check("ack_latency", 32'(cyc - issue_cyc), 32'(1 + LAT));
                if (e.exp_cyc >= 0) check("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
                if (e.is_d) check("d_rdata", d_rdata, e.data);
                else        check("i_rdata", i_rdata, e.data);
            end
        end
    end

    task automatic i_access(input logic [31:0] addr, input logic hold);
        bit got;
        i_req  = 1'b1;
        i_addr = addr;
        got    = 1'b0;
        if (hold) begin
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk);
                if (i_ack) got = 1'b1;
            end
            if (!got) check("i_ack_timeout", 32'(got), 32'h1);
        end else begin
            @(negedge clk);
        end
        i_req = 1'b0;
    endtask

    task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        bit got;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        d_be    = be;
        got     = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (d_ack) got = 1'b1;
        end
        if (!got) check("d_ack_timeout", 32'(got), 32'h1);
    endtask

    // Back-to-back loads with d_req held high between them.
    task automatic d_seq(input int n, input logic [31:0] base);
        for (int j = 0; j < n; j++) d_access(1'b0, base + 32'(4 * j), 32'h0, 4'hF);
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (ack_q.size() == 0 && issue_q.size() == 0) done = 1'b1;
        end
        check("drain", 32'(ack_q.size() + issue_q.size()), 32'h0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset then idle.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_i_ack", 32'(i_ack), 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_d_ack", 32'(d_ack), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_be", 32'(mem_be), 32'h0);

        // Single fetch with a known instruction word.
        sim_mem[4] = 32'h0051_3023;
        ref_mem[4] = 32'h0051_3023;
        push(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, cyc + 2 + LAT, 1'b1);
        i_access(32'h10, 1'b1);
        check("fetch_i_rdata", i_rdata, 32'h0051_3023);
        wait_idle();

        // Store, load back, partial store, load back.
        push(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, cyc + 2 + LAT, 1'b1);
        d_access(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        d_req = 1'b0;
        check("store_keeps_d_rdata", d_rdata, 32'h0);
        wait_idle();
        push(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, cyc + 2 + LAT, 1'b1);
        d_access(1'b0, 32'h100, 32'h0, 4'hF);
        d_req = 1'b0;
        check("load_after_store", d_rdata, 32'hDEAD_BEEF);
        wait_idle();
        push(1'b1, 1'b1, 32'h100, 32'h1234_5678, 4'h5, -1, 1'b1);
        d_access(1'b1, 32'h100, 32'h1234_5678, 4'h5);
        push(1'b1, 1'b0, 32'h100, 32'h0, 4'hF, -1, 1'b1);
        d_access(1'b0, 32'h100, 32'h0, 4'hF);
        d_req = 1'b0;
        check("partial_store_merge", d_rdata, 32'hDE34_BE78);
        wait_idle();

        // Simultaneous requests: D served first, I in the following IDLE.
        push(1'b1, 1'b0, 32'h300, 32'h0, 4'hF, cyc + 2 + LAT, 1'b1);
        push(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, cyc + 5 + 2 * LAT, 1'b1);
        fork
            d_seq(1, 32'h300);
            i_access(32'h20, 1'b1);
        join
        wait_idle();

        // Long D burst against a waiting fetch.
`ifdef MEM_ARB_STARVE_GUARD_EN
        push(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, -1, 1'b1);
        push(1'b1, 1'b0, 32'h204, 32'h0, 4'hF, -1, 1'b1);
        push(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, -1, 1'b1);
        push(1'b1, 1'b0, 32'h208, 32'h0, 4'hF, -1, 1'b1);
`else
        push(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, -1, 1'b1);
        push(1'b1, 1'b0, 32'h204, 32'h0, 4'hF, -1, 1'b1);
        push(1'b1, 1'b0, 32'h208, 32'h0, 4'hF, -1, 1'b1);
        push(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, -1, 1'b1);
`endif
        fork
            d_seq(3, 32'h200);
            i_access(32'h40, 1'b1);
        join
        wait_idle();

        // Abandoned fetch: request dropped right after the grant still completes.
        push(1'b0, 1'b0, 32'h60, 32'h0, 4'h0, cyc + 2 + LAT, 1'b1);
        i_access(32'h60, 1'b0);
        wait_idle();

        // Reset while waiting on memory: no ack, then normal service.
        push(1'b0, 1'b0, 32'h80, 32'h0, 4'h0, -1, 1'b0);
        i_req  = 1'b1;
        i_addr = 32'h80;
        @(negedge clk);
        i_req = 1'b0;
        check("abort_mem_en", 32'(mem_en), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_d_rdata = 32'h0;
        check("abort_i_ack", 32'(i_ack), 32'h0);
        check("abort_i_rdata", i_rdata, 32'h0);
        check("abort_d_rdata", d_rdata, 32'h0);
        check("abort_mem_en_low", 32'(mem_en), 32'h0);
        push(1'b0, 1'b0, 32'h84, 32'h0, 4'h0, cyc + 2 + LAT, 1'b1);
        i_access(32'h84, 1'b1);
        wait_idle();

        check("issue_q_empty", 32'(issue_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
